// File: rtl/seven_seg_digit_driver.sv
// Cathode driver for a 4-digit, active-low 7-segment display scanned by an external anode scanner.
// Optional leading-zero blanking is compiled in with `define SEVSEG_LEADING_ZERO_BLANK_EN.
module seven_seg_digit_driver #(
  parameter int unsigned BLANK_CYCLES = 2,
  parameter logic [3:0]  DIGIT0_ANODE = 4'b1110
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  output logic        load_ready,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_done,
  output logic        anode_error,
  output logic        dbg_load_state
);

  // Handshake: a load transfers on a rising edge where load_valid && load_ready;
  // load_ready is low from the transfer until the frame boundary that commits it.

  localparam int CNT_W = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} load_state_t;

  function automatic logic one_cold(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] cold_index(input logic [3:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    case (a)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Active-low patterns, bit order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_OFF;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  load_state_t      r_state;
  logic [3:0]       r_anode_q;
  logic [15:0]      r_shadow_data;
  logic [3:0]       r_shadow_dp;
  logic [15:0]      r_active_data;
  logic [3:0]       r_active_dp;
  logic [CNT_W-1:0] r_blank_cnt;
  logic             r_load_ready;
  logic             r_frame_done;
  logic             r_anode_error;
  logic [6:0]       r_segments;
  logic             r_dp;

  logic             w_anode_change;
  logic             w_frame_next;
  logic             w_commit;
  logic [15:0]      w_disp_data;
  logic [3:0]       w_disp_dp;
  logic [1:0]       w_digit;
  logic [3:0]       w_nibble;
  logic             w_dp_bit;
  logic             w_legal;
  logic             w_lz_blank;
  logic             w_off;

  // Change and boundary are judged one edge early against the incoming anode, so the
  // registered flags line up exactly with the cycle the new pattern sits in r_anode_q.
  assign w_anode_change = (anode != r_anode_q);
  assign w_frame_next   = (anode == DIGIT0_ANODE) && (r_anode_q != DIGIT0_ANODE) && one_cold(r_anode_q);

  // A commit shows on digit 0 immediately by bypassing the shadow into the decoder.
  assign w_commit    = (r_state == ST_PENDING) && r_frame_done;
  assign w_disp_data = w_commit ? r_shadow_data : r_active_data;
  assign w_disp_dp   = w_commit ? r_shadow_dp   : r_active_dp;
  assign w_legal     = one_cold(r_anode_q);
  assign w_digit     = cold_index(r_anode_q);
  assign w_nibble    = w_disp_data[{w_digit, 2'b00} +: 4];
  assign w_dp_bit    = w_disp_dp[w_digit];

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_lz_blank = 1'b0;
    case (w_digit)
      2'd3: w_lz_blank = (w_disp_data[15:12] == 4'h0)  && !w_disp_dp[3];
      2'd2: w_lz_blank = (w_disp_data[15:8]  == 8'h00) && !w_disp_dp[2];
      2'd1: w_lz_blank = (w_disp_data[15:4]  == 12'h0) && !w_disp_dp[1];
      default: w_lz_blank = 1'b0;
    endcase
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_off = !w_legal || (r_blank_cnt != '0) || w_lz_blank;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_anode_q     <= 4'hF;
      r_frame_done  <= 1'b0;
      r_anode_error <= 1'b0;
      r_blank_cnt   <= '0;
      r_segments    <= SEG_OFF;
      r_dp          <= 1'b1;
    end else begin
      r_anode_q     <= anode;
      r_frame_done  <= w_frame_next;
      r_anode_error <= !one_cold(anode);
      if (w_anode_change) begin
        r_blank_cnt <= BLANK_LOAD;
      end else if (r_blank_cnt != '0) begin
        r_blank_cnt <= r_blank_cnt - CNT_W'(1);
      end
      r_segments <= w_off ? SEG_OFF : hex_to_seg(w_nibble);
      r_dp       <= w_off ? 1'b1 : !w_dp_bit;
    end
  end

  // Load FSM: shadow is written on acceptance, active only at a frame boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_load_ready  <= 1'b1;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_active_data <= '0;
      r_active_dp   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_valid) begin
            r_shadow_data <= load_data;
            r_shadow_dp   <= load_dp;
            r_state       <= ST_PENDING;
            r_load_ready  <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (r_frame_done) begin
            r_active_data <= r_shadow_data;
            r_active_dp   <= r_shadow_dp;
            r_state       <= ST_IDLE;
            r_load_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready     = r_load_ready;
  assign segments       = r_segments;
  assign dp             = r_dp;
  assign frame_done     = r_frame_done;
  assign anode_error    = r_anode_error;
  assign dbg_load_state = (r_state == ST_PENDING);

endmodule

// File: doc/seven_seg_digit_driver.md
Name: seven_seg_digit_driver

Overview:
Cathode-side partner of the anode scanner. It consumes the active-low one-hot anode scan and drives the matching active-low segment and decimal-point cathodes for the digit currently enabled. It holds a double-buffered 4-digit hex display value, loaded through a valid/ready handshake. New values are committed only at a frame boundary, so the display never tears. It blanks the cathodes briefly after every anode change to suppress ghosting.

Parameters:
BLANK_CYCLES, 2, clock cycles the cathodes are forced off after each anode change; 0 disables blanking.
DIGIT0_ANODE, 4'b1110, anode pattern that marks digit 0 and the frame boundary.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
anode  input  4  active-low one-hot digit select from the scanner; synchronous to clock; bit0 = rightmost digit.
load_valid  input  1  a new display value is offered.
load_data  input  16  four hex nibbles; [3:0] = digit 0 (rightmost).
load_dp  input  4  decimal-point enables, 1 = lit; bit i = digit i.
load_ready  output  1  the driver can accept a load this cycle.
segments  output  7  active-low cathodes; [0]=a ... [6]=g.
dp  output  1  active-low decimal-point cathode.
frame_done  output  1  one-cycle pulse when a frame boundary is detected.
anode_error  output  1  high while the sampled anode is not exactly one-hot-low.

Behaviour:
- Reset values (async, active-low): segments=7'h7F, dp=1, load_ready=1, frame_done=0, anode_error=0. anode_q=4'hF. Shadow and active registers = 0. dp registers = 0. pending=0. blank counter=0.
- anode is registered into anode_q every cycle. "Anode change" means anode_q != previous anode_q.
- Load FSM has two states, IDLE and PENDING:
  - IDLE: load_ready=1. If load_valid, capture load_data/load_dp into the shadow register and go to PENDING.
  - PENDING: load_ready=0; load_valid is ignored. On a frame boundary, copy shadow to active, return to IDLE, and raise load_ready in the following cycle.
- Frame boundary: anode_q becomes DIGIT0_ANODE from a different value that is also a legal one-hot pattern. In that same cycle frame_done=1 and the commit happens; the new value applies to digit 0 of this frame.
- If the scanner stalls, the driver stays in PENDING indefinitely. There is no timeout.
- Digit select: the index of the single 0 bit in anode_q selects the nibble and dp bit from the active register.
- Hex decode, segments as g..a: 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011, C → 1000110, d → 0100001, E → 0000110, F → 0001110.
- segments and dp are registered. Latency: an anode change at the input reaches the outputs 2 edges later (anode_q, then the output register).
- Blanking: each anode change loads the blank counter with BLANK_CYCLES. While the counter is nonzero, segments=7'h7F and dp=1, and the counter decrements once per cycle. A further anode change during blanking reloads the counter.
- Illegal anode_q (not exactly one 0 bit, including 4'hF): anode_error=1, segments=7'h7F, dp=1. No frame boundary is detected. The next legal pattern clears anode_error in the cycle it is sampled.
- Reset asserted mid-operation clears everything immediately, including a pending load, which is lost.

Optional Feature:
SEVSEG_LEADING_ZERO_BLANK_EN: when defined, digits 3..1 are blanked (segments=7'h7F) if their nibble and every higher nibble are 0 and their dp bit is 0. Digit 0 is always shown, so 0x0000 displays as a single "0". When undefined, all four digits always display.

Test Plan:
- Reset → segments=7'h7F, dp=1, load_ready=1, frame_done=0, anode_error=0. Anode cycled 1110,1101,1011,0111 with BLANK_CYCLES=0 → every digit shows "0" (7'b1000000).
- While anode=1011, load 0x1234 → load_ready=0 next cycle; display unchanged until anode returns to 1110. Then frame_done pulses, digit 0 shows 4 (0011001), and the rest of the frame shows 3, 2, 1.
- A second load_valid while PENDING → not accepted; after commit the shadow still holds the first value.
- BLANK_CYCLES=2, anode changes → segments=7'h7F for 2 cycles after the change reaches anode_q, then the decoded digit.
- anode=1100 → anode_error=1 and cathodes off; next anode=1110 → no frame_done, error clears, and the digit then displays after the blanking period.
- reset asserted while PENDING with 0xBEEF loaded → after release the display shows 0x0000 and load_ready=1; with SEVSEG_LEADING_ZERO_BLANK_EN, digits 3..1 stay blank.
